// File: rtl/ldtu_link_pkg.sv
// ldtu_link_pkg
// Shared definitions for the LiTE-DTU serial link: receiver state encoding,
// word/phase widths and the default idle synchronisation word (also used by
// the serializer bench so both ends agree on the pattern).
package ldtu_link_pkg;

    localparam int LDTU_NBITS   = 32;
    localparam int LDTU_PHASE_W = 5;

    localparam logic [LDTU_NBITS-1:0] LDTU_SYNC_PATTERN = 32'h5A5AF0F0;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } link_state_e;

endpackage

// File: rtl/ldtu_sat_counter.sv
// ldtu_sat_counter
// Event counter with synchronous clear. SATURATE=1 holds at all-ones,
// SATURATE=0 wraps.
//   i_clk    : clock
//   i_rst_b  : synchronous active-low reset
//   i_clr    : clear (wins over i_inc)
//   i_inc    : count one event
//   o_count  : current count
module ldtu_sat_counter #(
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_b,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_hold;

    assign w_hold = SATURATE && (&r_count);

    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_hold) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ldtu_ser_receiver.sv
// ldtu_ser_receiver
// Far-end receiver of one LiTE-DTU serializer lane (CLK_SRL domain).
// Deserializes the MSB-first stream, hunts for the sync word to find the
// 32-bit boundary, verifies it over several frames, then delivers aligned
// words and watches for loss of alignment while the link idles in sync mode.
//
// Ports:
//   clock        : serial bit clock, one bit per rising edge
//   rst_b        : synchronous active-low reset
//   serial_in    : serial data, MSB first
//   sync_mode    : transmitter is sending the idle sync word
//   sync_pattern : expected sync word
//   realign      : single-cycle request to restart the hunt
//   data_out     : last aligned word
//   data_valid   : one-cycle strobe, data_out updated
//   locked       : alignment established
//   lock_lost    : one-cycle pulse when leaving LOCKED
//   phase        : bit position within the current word
//   word_count   : words delivered since lock (wraps)
//   err_count    : sync-mode boundary mismatches while locked (saturates)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HUNT   | searching every bit position for the sync word
// ST_VERIFY | candidate boundary found, confirming on following frames
// ST_LOCKED | aligned; words delivered at each boundary
module ldtu_ser_receiver
    import ldtu_link_pkg::*;
#(
    parameter int NBITS      = LDTU_NBITS,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clock,
    input  logic                    rst_b,
    input  logic                    serial_in,
    input  logic                    sync_mode,
    input  logic [NBITS-1:0]        sync_pattern,
    input  logic                    realign,
    output logic [NBITS-1:0]        data_out,
    output logic                    data_valid,
    output logic                    locked,
    output logic                    lock_lost,
    output logic [LDTU_PHASE_W-1:0] phase,
    output logic [CNT_W-1:0]        word_count,
    output logic [CNT_W-1:0]        err_count
);

    localparam logic [LDTU_PHASE_W-1:0] PH_LAST  = LDTU_PHASE_W'(NBITS - 1);
    localparam logic [3:0]              LOCK_TGT = 4'(LOCK_COUNT);
    localparam logic [3:0]              LOSS_TGT = 4'(LOSS_COUNT);

    link_state_e               r_state;
    logic [NBITS-1:0]          r_sr;
    logic [LDTU_PHASE_W-1:0]   r_phase;
    logic [3:0]                r_match_cnt;
    logic [3:0]                r_loss_cnt;
    logic [NBITS-1:0]          r_data_out;
    logic                      r_data_valid;
    logic                      r_locked;
    logic                      r_lock_lost;

    link_state_e               w_state_nxt;
    logic [LDTU_PHASE_W-1:0]   w_phase_nxt;
    logic [LDTU_PHASE_W-1:0]   w_phase_adv;
    logic [3:0]                w_match_cnt_nxt;
    logic [3:0]                w_loss_cnt_nxt;
    logic [3:0]                w_match_inc;
    logic [3:0]                w_loss_inc;
    logic                      w_match;
    logic                      w_boundary;
    logic                      w_dv_nxt;
    logic                      w_ll_nxt;
    logic                      w_wc_inc;
    logic                      w_wc_clr;
    logic                      w_err_inc;

    assign w_match     = (r_sr == sync_pattern);
    assign w_boundary  = (r_phase == PH_LAST);
    assign w_phase_adv = w_boundary ? '0 : r_phase + LDTU_PHASE_W'(1);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_loss_inc  = r_loss_cnt + 4'd1;

    always_ff @(posedge clock) begin
        if (!rst_b) begin
            r_state      <= ST_HUNT;
            r_sr         <= '0;
            r_phase      <= '0;
            r_match_cnt  <= '0;
            r_loss_cnt   <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= {r_sr[NBITS-2:0], serial_in};
            r_phase      <= w_phase_nxt;
            r_match_cnt  <= w_match_cnt_nxt;
            r_loss_cnt   <= w_loss_cnt_nxt;
            r_data_valid <= w_dv_nxt;
            r_locked     <= (w_state_nxt == ST_LOCKED);
            r_lock_lost  <= w_ll_nxt;
            if (w_dv_nxt) begin
                r_data_out <= r_sr;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_match_cnt_nxt = r_match_cnt;
        w_loss_cnt_nxt  = r_loss_cnt;
        w_dv_nxt        = 1'b0;
        w_ll_nxt        = 1'b0;
        w_wc_inc        = 1'b0;
        w_wc_clr        = 1'b0;
        w_err_inc       = 1'b0;

        if (realign) begin
            // Realign beats a coincident boundary: no word is delivered.
            w_state_nxt     = ST_HUNT;
            w_phase_nxt     = '0;
            w_match_cnt_nxt = '0;
            w_loss_cnt_nxt  = '0;
            w_wc_clr        = 1'b1;
            w_ll_nxt        = (r_state == ST_LOCKED);
        end else begin
            case (r_state)
                ST_HUNT: begin
                    w_phase_nxt = '0;
                    if (w_match) begin
                        w_match_cnt_nxt = 4'd1;
                        w_state_nxt     = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    w_phase_nxt = w_phase_adv;
                    if (w_boundary) begin
                        if (w_match) begin
                            w_match_cnt_nxt = w_match_inc;
                            if (w_match_inc == LOCK_TGT) begin
                                w_state_nxt     = ST_LOCKED;
                                w_match_cnt_nxt = '0;
                            end
                        end else begin
                            w_match_cnt_nxt = '0;
                            w_phase_nxt     = '0;
                            w_state_nxt     = ST_HUNT;
                        end
                    end
                end

                ST_LOCKED: begin
                    w_phase_nxt = w_phase_adv;
                    if (w_boundary) begin
                        w_dv_nxt = 1'b1;
                        w_wc_inc = 1'b1;
                        // Only idle sync frames can be checked; data frames are opaque.
                        if (sync_mode && !w_match) begin
                            w_err_inc = 1'b1;
                            if (w_loss_inc == LOSS_TGT) begin
                                w_state_nxt    = ST_HUNT;
                                w_loss_cnt_nxt = '0;
                                w_phase_nxt    = '0;
                                w_ll_nxt       = 1'b1;
                                w_wc_clr       = 1'b1;
                            end else begin
                                w_loss_cnt_nxt = w_loss_inc;
                            end
                        end else begin
                            w_loss_cnt_nxt = '0;
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_HUNT;
                    w_phase_nxt = '0;
                end
            endcase
        end
    end

    ldtu_sat_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b0)
    ) u_word_cnt (
        .i_clk   (clock),
        .i_rst_b (rst_b),
        .i_clr   (w_wc_clr),
        .i_inc   (w_wc_inc),
        .o_count (word_count)
    );

    ldtu_sat_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .i_clk   (clock),
        .i_rst_b (rst_b),
        .i_clr   (1'b0),
        .i_inc   (w_err_inc),
        .o_count (err_count)
    );

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign locked     = r_locked;
    assign lock_lost  = r_lock_lost;
    assign phase      = r_phase;

endmodule

// File: tb/tb_ldtu_ser_receiver.sv
// tb_ldtu_ser_receiver
// Directed bench for ldtu_ser_receiver: initial hunt and lock at an odd bit
// offset, data delivery, bit slip and relock, realign on a boundary, VERIFY
// failure, and reset in the middle of a locked word.
module tb_ldtu_ser_receiver;
    import ldtu_link_pkg::*;

    logic        clock;
    logic        rst_b;
    logic        serial_in;
    logic        sync_mode;
    logic [31:0] sync_pattern;
    logic        realign;
    logic [31:0] data_out;
    logic        data_valid;
    logic        locked;
    logic        lock_lost;
    logic [4:0]  phase;
    logic [15:0] word_count;
    logic [15:0] err_count;

    logic [31:0] P;
    int          n_checks;
    int          n_pass;
    int          n_fail;

    ldtu_ser_receiver dut (
        .clock        (clock),
        .rst_b        (rst_b),
        .serial_in    (serial_in),
        .sync_mode    (sync_mode),
        .sync_pattern (sync_pattern),
        .realign      (realign),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .locked       (locked),
        .lock_lost    (lock_lost),
        .phase        (phase),
        .word_count   (word_count),
        .err_count    (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b);
        serial_in = b;
        @(posedge clock);
        #1;
    endtask

    task automatic send_range(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) step(w[i]);
    endtask

    // Sends one word MSB first. sync_mode for this word is applied from its
    // second bit so it is in effect during the word's own boundary cycle.
    // Checks after the first bit observe the previous word's boundary.
    task automatic send_word(input logic [31:0] w, input logic sm, input bit do_chk,
                             input string nm, input logic exp_dv, input logic [31:0] exp_data,
                             input int exp_wc, input logic exp_lk, input logic exp_ll);
        step(w[31]);
        if (do_chk) begin
            chk({nm, "_dv"}, data_valid, exp_dv);
            if (exp_dv) chk({nm, "_data"}, data_out, exp_data);
            chk({nm, "_wc"}, word_count, exp_wc);
            chk({nm, "_locked"}, locked, exp_lk);
            chk({nm, "_lock_lost"}, lock_lost, exp_ll);
            chk({nm, "_phase"}, phase, 0);
        end
        sync_mode = sm;
        step(w[30]);
        if (do_chk && exp_dv) chk({nm, "_dv_pulse"}, data_valid, 1'b0);
        send_range(w, 29, 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_data"}, data_out, 0);
        chk({nm, "_dv"}, data_valid, 0);
        chk({nm, "_locked"}, locked, 0);
        chk({nm, "_lock_lost"}, lock_lost, 0);
        chk({nm, "_phase"}, phase, 0);
        chk({nm, "_wc"}, word_count, 0);
        chk({nm, "_err"}, err_count, 0);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        n_fail       = 0;
        P            = LDTU_SYNC_PATTERN;
        rst_b        = 1'b0;
        serial_in    = 1'b0;
        sync_mode    = 1'b1;
        sync_pattern = P;
        realign      = 1'b0;

        repeat (3) step(1'b0);
        chk_reset_vals("rst");
        rst_b = 1'b1;

        // Initial lock at bit offset 13.
        repeat (13) step(1'b0);
        send_word(P, 1'b1, 1'b0, "w1", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "w2", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "w3", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "w4", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        chk("lock_early", locked, 1'b0);
        // First bit of word 5 is cycle first_match + 97: locked must be high.
        send_word(32'h00000001, 1'b0, 1'b1, "w5", 1'b0, 32'h0, 0, 1'b1, 1'b0);

        // Data words.
        send_word(32'hDEADBEEF, 1'b0, 1'b1, "w6", 1'b1, 32'h00000001, 1, 1'b1, 1'b0);
        send_word(P, 1'b1, 1'b1, "w7", 1'b1, 32'hDEADBEEF, 2, 1'b1, 1'b0);
        send_word(P, 1'b1, 1'b1, "w8", 1'b1, P, 3, 1'b1, 1'b0);

        // One extra bit slips the stream by one position.
        step(1'b0);
        chk("slip0_dv", data_valid, 1'b1);
        chk("slip0_data", data_out, P);
        chk("slip0_wc", word_count, 4);
        send_word(P, 1'b1, 1'b0, "w9", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        chk("slip1_dv", data_valid, 1'b1);
        chk("slip1_data", data_out, 32'h2D2D7878);
        chk("slip1_err", err_count, 1);
        chk("slip1_locked", locked, 1'b1);
        chk("slip1_lock_lost", lock_lost, 1'b0);
        chk("slip1_wc", word_count, 5);
        send_word(P, 1'b1, 1'b0, "w10", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        chk("slip2_dv", data_valid, 1'b1);
        chk("slip2_data", data_out, 32'h2D2D7878);
        chk("slip2_err", err_count, 2);
        chk("slip2_locked", locked, 1'b0);
        chk("slip2_lock_lost", lock_lost, 1'b1);
        chk("slip2_wc", word_count, 0);
        // Word 10 completes in the cycle HUNT is entered: first match there.
        send_word(P, 1'b1, 1'b1, "w11", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "w12", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "w13", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "w14", 1'b0, 32'h0, 0, 1'b1, 1'b0);
        send_word(P, 1'b1, 1'b1, "w15", 1'b1, P, 1, 1'b1, 1'b0);

        // Realign coincident with the boundary of word 15.
        realign = 1'b1;
        step(P[31]);
        realign = 1'b0;
        chk("rl_dv", data_valid, 1'b0);
        chk("rl_lock_lost", lock_lost, 1'b1);
        chk("rl_wc", word_count, 0);
        chk("rl_locked", locked, 1'b0);
        chk("rl_err", err_count, 2);
        chk("rl_phase", phase, 0);
        send_range(P, 30, 0);

        // VERIFY with the third boundary corrupted.
        send_word(P, 1'b1, 1'b1, "v1", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "v2", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P ^ 32'h00000001, 1'b1, 1'b1, "v3", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        step(P[31]);
        chk("vfail_locked", locked, 1'b0);
        chk("vfail_phase", phase, 0);
        chk("vfail_err", err_count, 2);
        step(P[30]);
        chk("vfail_hunt_phase", phase, 0);
        send_range(P, 29, 0);
        send_word(P, 1'b1, 1'b1, "r1", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "r2", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "r3", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "r4", 1'b0, 32'h0, 0, 1'b1, 1'b0);

        // Reset for one cycle in the middle of a locked word.
        send_range(P, 31, 16);
        chk("prerst_locked", locked, 1'b1);
        chk("prerst_wc", word_count, 1);
        rst_b = 1'b0;
        step(P[15]);
        rst_b = 1'b1;
        chk_reset_vals("midrst");
        repeat (15) step(1'b0);
        send_word(P, 1'b1, 1'b0, "s0", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "s1", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "s2", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "s3", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        send_word(P, 1'b1, 1'b1, "s4", 1'b0, 32'h0, 0, 1'b1, 1'b0);
        chk("final_err", err_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
